sha256_block_sched: RTL and testbench

//  Sequences the iterative sha256 compression core over multi-block messages.

---
 rtl/sha256_block_sched.sv | 133 +++++++++++++
 tb/tb_sha256_block_sched.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_sched.sv
// Multi-block SHA-256 sequencer: accepts padded blocks, drives the iterative core and chains results.
// Optional SHA256_SCHED_DBLHASH_EN re-hashes the message digest once more (SHA-256d).
module sha256_block_sched #(
  parameter int unsigned  CNT_W = 16,
  parameter logic [255:0] IV    = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             blk_valid,
  output logic             blk_ready,
  input  logic [511:0]     blk_data,
  input  logic             blk_first,
  input  logic             blk_last,
  output logic             dig_valid,
  input  logic             dig_ready,
  output logic [255:0]     dig_data,
  output logic             core_start,
  output logic [255:0]     core_h_in,
  output logic [511:0]     core_m_in,
  input  logic             core_done,
  input  logic [255:0]     core_h_out,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int unsigned H_W = 256;
  localparam int unsigned M_W = 512;

`ifdef SHA256_SCHED_DBLHASH_EN
  // Padding tail of a single 256-bit message: 0x80 marker, zeros, bit length 256.
  localparam logic [M_W-H_W-1:0] DBL_PAD = {32'h8000_0000, 160'b0, 64'd256};
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
`ifdef SHA256_SCHED_DBLHASH_EN
    , S_DSTART,
    S_DWAIT
`endif
  } state_t;

  state_t         state;
  logic [H_W-1:0] h_reg;
  logic [M_W-1:0] m_reg;
  logic [H_W-1:0] chain_reg;
  logic           last_reg;
  logic           accept;

  assign accept    = blk_valid && blk_ready;
  assign core_h_in = h_reg;
  assign core_m_in = m_reg;

  // Sequencer; blk_ready and busy are kept as registers that track the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      h_reg      <= '0;
      m_reg      <= '0;
      chain_reg  <= '0;
      last_reg   <= 1'b0;
      blk_cnt    <= '0;
      dig_data   <= '0;
      dig_valid  <= 1'b0;
      core_start <= 1'b0;
      blk_ready  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      core_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            m_reg      <= blk_data;
            h_reg      <= blk_first ? IV : chain_reg;
            last_reg   <= blk_last;
            if (blk_first) blk_cnt <= '0;
            core_start <= 1'b1;
            blk_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= S_START;
          end else begin
            blk_ready <= 1'b1;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (core_done) begin
            chain_reg <= core_h_out;
            if (blk_cnt != '1) blk_cnt <= blk_cnt + CNT_W'(1);
            if (last_reg) begin
`ifdef SHA256_SCHED_DBLHASH_EN
              h_reg      <= IV;
              m_reg      <= {core_h_out, DBL_PAD};
              core_start <= 1'b1;
              state      <= S_DSTART;
`else
              dig_data  <= core_h_out;
              dig_valid <= 1'b1;
              state     <= S_DONE;
`endif
            end else begin
              blk_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= S_IDLE;
            end
          end
        end
`ifdef SHA256_SCHED_DBLHASH_EN
        S_DSTART: state <= S_DWAIT;
        S_DWAIT: begin
          if (core_done) begin
            dig_data  <= core_h_out;
            dig_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (dig_ready) begin
            dig_valid <= 1'b0;
            blk_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_block_sched.sv
// Bench for sha256_block_sched: behavioural SHA-256 core plus message-level reference model.
module tb_sha256_block_sched;

  localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ABC_DBL  = 256'h4f8b42c22dd3729b519ba6f68d2da7cc5b2d606d05daed5ad5128cc03e6c6358;
  localparam logic [255:0] NIST_DIG = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
`ifdef SHA256_SCHED_DBLHASH_EN
  localparam bit DBL = 1'b1;
  localparam int DIG_LAT = 135;
`else
  localparam bit DBL = 1'b0;
  localparam int DIG_LAT = 68;
`endif

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          blk_valid = 1'b0;
  logic          blk_ready;
  logic [511:0]  blk_data = '0;
  logic          blk_first = 1'b0;
  logic          blk_last = 1'b0;
  logic          dig_valid;
  logic          dig_ready = 1'b0;
  logic [255:0]  dig_data;
  logic          core_start;
  logic [255:0]  core_h_in;
  logic [511:0]  core_m_in;
  logic          core_done;
  logic [255:0]  core_h_out;
  logic          busy;
  logic [15:0]   blk_cnt;

  logic          m_done = 1'b0;
  logic [255:0]  m_h = '0;
  logic          f_done = 1'b0;
  logic [255:0]  f_h = '0;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_start = 0;
  int stab_err = 0;
  int mcnt = 0;
  logic [255:0] mres, cap_h;
  logic [511:0] cap_m;

  logic [255:0] mdl_h = '0;
  int           mdl_cnt = 0;

  assign core_done  = m_done | f_done;
  assign core_h_out = f_done ? f_h : m_h;

  sha256_block_sched dut (
    .clk(clk), .rst_n(rst_n),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_first(blk_first), .blk_last(blk_last),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .core_start(core_start), .core_h_in(core_h_in), .core_m_in(core_m_in),
    .core_done(core_done), .core_h_out(core_h_out),
    .busy(busy), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (core_start) n_start++;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // SHA-256 compression of one block onto a chaining value.
  function automatic logic [255:0] compress(input logic [255:0] hv, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = hv;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hv[255:224] + a, hv[223:192] + b, hv[191:160] + c, hv[159:128] + d,
            hv[127:96] + e, hv[95:64] + f, hv[63:32] + g, hv[31:0] + h};
  endfunction

  function automatic logic [255:0] dbl_fin(input logic [255:0] h);
    return DBL ? compress(IV, {h, 32'h8000_0000, 160'b0, 64'd256}) : h;
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = $urandom;
    return r;
  endfunction

  // Behavioural core: done 66 cycles after the start cycle; inputs must stay stable meanwhile.
  always @(negedge clk) begin
    m_done = 1'b0;
    if (!rst_n) begin
      mcnt = 0;
    end else begin
      if (mcnt != 0) begin
        if (core_h_in !== cap_h || core_m_in !== cap_m) stab_err++;
        mcnt--;
        if (mcnt == 0) begin
          m_done = 1'b1;
          m_h    = mres;
        end
      end
      if (core_start) begin
        cap_h = core_h_in;
        cap_m = core_m_in;
        mres  = compress(core_h_in, core_m_in);
        mcnt  = 66;
      end
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_block(input logic [511:0] d, input bit f, input bit l,
                            input logic [255:0] exp_h, output int t_acc);
    int guard = 0;
    blk_data = d; blk_first = f; blk_last = l; blk_valid = 1'b1;
    while (!blk_ready && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", 512'(blk_ready), 512'(1));
    t_acc = cyc;
    @(negedge clk);
    blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    check("core_start_t1", 512'(core_start), 512'(1));
    check("core_h_in", 512'(core_h_in), 512'(exp_h));
    check("core_m_in", core_m_in, d);
  endtask

  task automatic get_digest(input int hold, input bit hold_valid, input bit pulse,
                            output logic [255:0] dig, output int t_dv);
    int guard = 0;
    int bad = 0;
    int s0;
    while (!dig_valid && guard < 4000) begin
      @(negedge clk);
      guard++;
    end
    check("dig_valid_seen", 512'(dig_valid), 512'(1));
    t_dv = cyc;
    dig  = dig_data;
    s0   = n_start;
    blk_valid = hold_valid;
    if (pulse) begin
      f_h    = {8{32'($urandom)}};
      f_done = 1'b1;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      f_done = 1'b0;
      if (dig_valid !== 1'b1 || dig_data !== dig || blk_ready !== 1'b0 || core_start !== 1'b0) bad++;
    end
    if (hold > 0) check("hold_stable", 512'(bad), 512'(0));
    dig_ready = 1'b1;
    @(negedge clk);
    dig_ready = 1'b0;
    blk_valid = 1'b0;
    check("dig_clear", 512'({dig_valid, busy, blk_ready}), 512'(3'b001));
    check("no_accept_in_done", 512'(n_start - s0), 512'(0));
  endtask

  // One block through the scheduler, checked against the message-level model.
  task automatic do_block(input logic [511:0] d, input bit f, input bit l, input int hold,
                          input bit hold_valid, input bit pulse,
                          output logic [255:0] dig, output int lat);
    logic [255:0] hin;
    int s0, se0, t_acc, t_dv;
    int guard = 0;
    hin = f ? IV : mdl_h;
    s0  = n_start;
    se0 = stab_err;
    dig = '0;
    lat = 0;
    send_block(d, f, l, hin, t_acc);
    mdl_h   = compress(hin, d);
    mdl_cnt = f ? 1 : ((mdl_cnt < 65535) ? mdl_cnt + 1 : 65535);
    if (l) begin
      get_digest(hold, hold_valid, pulse, dig, t_dv);
      lat = t_dv - t_acc;
      check("digest", 512'(dig), 512'(dbl_fin(mdl_h)));
      check("start_pulses", 512'(n_start - s0), 512'(DBL ? 2 : 1));
    end else begin
      while (!blk_ready && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      check("back_to_idle", 512'(blk_ready), 512'(1));
      check("start_pulses", 512'(n_start - s0), 512'(1));
    end
    check("blk_cnt", 512'(blk_cnt), 512'(mdl_cnt));
    check("inputs_stable", 512'(stab_err - se0), 512'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, 512'({blk_ready, dig_valid, core_start, busy}), 512'(0));
    check({tag, "_dig"}, 512'(dig_data), 512'(0));
    check({tag, "_hin"}, 512'(core_h_in), 512'(0));
    check({tag, "_min"}, core_m_in, 512'(0));
    check({tag, "_cnt"}, 512'(blk_cnt), 512'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc, n1, n2;
    logic [255:0] dig, prev_dig;
    int lat, s0, ta, nb;
    bit f;

    abc = '0;
    abc[511:480] = 32'h6162_6380;
    abc[31:0]    = 32'h0000_0018;
    n1 = '0;
    for (int i = 0; i < 14; i++)
      n1[511-32*i -: 32] = {8'(97 + i), 8'(98 + i), 8'(99 + i), 8'(100 + i)};
    n1[63:32] = 32'h8000_0000;
    n2 = '0;
    n2[31:0] = 32'h0000_01c0;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 512'({blk_ready, busy}), 512'(2'b10));

    // Single-block "abc"
    do_block(abc, 1'b1, 1'b1, 0, 1'b0, 1'b0, dig, lat);
    check("abc_const", 512'(dig), 512'(DBL ? ABC_DBL : ABC_DIG));
    check("abc_latency", 512'(lat), 512'(DIG_LAT));

    // Two-block NIST message
    do_block(n1, 1'b1, 1'b0, 0, 1'b0, 1'b0, dig, lat);
    do_block(n2, 1'b0, 1'b1, 0, 1'b0, 1'b0, dig, lat);
    check("nist_const", 512'(dig), 512'(dbl_fin(NIST_DIG)));
    prev_dig = dig;

    // Stray core_done while idle must be ignored
    s0 = n_start;
    f_h = {8{32'($urandom)}};
    f_done = 1'b1;
    @(negedge clk);
    f_done = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_done_cnt", 512'(blk_cnt), 512'(mdl_cnt));
    check("idle_done_dig", 512'(dig_data), 512'(prev_dig));
    check("idle_done_start", 512'(n_start - s0), 512'(0));
    check("idle_done_state", 512'({blk_ready, busy}), 512'(2'b10));
    do_block(rand_blk(), 1'b0, 1'b1, 0, 1'b0, 1'b0, dig, lat);

    // Backpressured digest with a block pending and a stray core_done in DONE
    do_block(abc, 1'b1, 1'b1, 10, 1'b1, 1'b1, dig, lat);
    check("abc_hold_const", 512'(dig), 512'(DBL ? ABC_DBL : ABC_DIG));
    do_block(rand_blk(), 1'b0, 1'b1, 0, 1'b0, 1'b0, dig, lat);

    // Asynchronous reset 30 cycles into a message
    send_block(abc, 1'b1, 1'b1, IV, ta);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midreset", 512'({blk_ready, dig_valid}), 512'(2'b10));
    do_block(abc, 1'b1, 1'b1, 0, 1'b0, 1'b0, dig, lat);
    check("abc_rerun_const", 512'(dig), 512'(DBL ? ABC_DBL : ABC_DIG));
    check("abc_rerun_latency", 512'(lat), 512'(DIG_LAT));

    // Random messages, including occasional mid-message restarts
    for (int m = 0; m < 8; m++) begin
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        f = (b == 0) || ($urandom_range(0, 5) == 0);
        do_block(rand_blk(), f, (b == nb - 1), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                 1'b0, dig, lat);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
